// File: rtl/fixed_p_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_p_div_pkg
//  Purpose  : Shared types and sizing helpers for the sequential fixed-point
//             restoring divider.
//  Revision : 1.0 - initial release
// ============================================================================
package fixed_p_div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Number of restoring iterations: the dividend is pre-shifted by the
    // fraction width, so every bit of the widened dividend yields one quotient bit.
    function automatic int div_iters(input int width, input int fract_width);
        return width + fract_width;
    endfunction

    // Counter width able to hold 0..N
    function automatic int div_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_p_div_step.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_p_div_step
//  Purpose  : One combinational restoring-division step: shift the next
//             dividend bit into the partial remainder and subtract the divisor
//             when it fits.
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_p_div_step #(
    parameter int width = 32
) (
    input  logic [width:0]   r_i,      // current partial remainder
    input  logic             d_bit_i,  // next dividend bit (MSB first)
    input  logic [width-1:0] v_i,      // divisor
    output logic [width:0]   r_o,      // next partial remainder
    output logic             q_o       // quotient bit for this step
);

    logic [width+1:0] w_t;
    logic [width:0]   w_diff;

    // The full shifted value takes part in the compare so a divide-by-zero
    // run (remainder never restored) still produces a 1 every step; the
    // stored remainder keeps only the low width+1 bits.
    assign w_t    = {r_i, d_bit_i};
    assign w_diff = w_t[width:0] - {1'b0, v_i};

    // Select restored or reduced remainder
    always_comb begin
        q_o = 1'b0;
        r_o = w_t[width:0];
        if (w_t >= {2'b00, v_i}) begin
            q_o = 1'b1;
            r_o = w_diff;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fixed_p_std_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_p_std_div_seq
//  Purpose  : Multi-cycle unsigned fixed-point divider, go/done handshake.
//             out = floor((left << fract_width) / right), one quotient bit
//             per clock; overflow flags quotient bits beyond width.
//  Revision : 1.0 - initial release
// ============================================================================
module fixed_p_std_div_seq
    import fixed_p_div_pkg::*;
#(
    parameter int width       = 32,
    parameter int int_width   = 8,
    parameter int fract_width = 24
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active low
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out,
    output logic             overflow,
    output logic             done
);

    localparam int N  = div_iters(width, fract_width);
    localparam int CW = div_cnt_width(N);

    if (int_width + fract_width != width) begin : g_param_check
        $error("fixed_p_std_div_seq: int_width + fract_width must equal width");
    end

    div_state_t       state_q, state_d;
    logic [N-1:0]     d_q, d_d;          // dividend shift register
    logic [width-1:0] v_q, v_d;          // latched divisor
    logic [width:0]   r_q, r_d;          // partial remainder
    logic [N-1:0]     quot_q, quot_d;    // quotient shift register
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;

    logic [width:0]   step_r;
    logic             step_q;
    logic [N-1:0]     quot_nx;

    fixed_p_div_step #(.width(width)) u_step (
        .r_i     (r_q),
        .d_bit_i (d_q[N-1]),
        .v_i     (v_q),
        .r_o     (step_r),
        .q_o     (step_q)
    );

    assign quot_nx = {quot_q[N-2:0], step_q};

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        v_d     = v_q;
        r_d     = r_q;
        quot_d  = quot_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    d_d     = N'(left) << fract_width;
                    v_d     = right;
                    r_d     = '0;
                    quot_d  = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                d_d    = {d_q[N-2:0], 1'b0};
                r_d    = step_r;
                quot_d = quot_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Results update only on the final iteration edge
                    out_d   = quot_nx[width-1:0];
                    ovf_d   = |(quot_nx >> width);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            v_q     <= '0;
            r_q     <= '0;
            quot_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            v_q     <= v_d;
            r_q     <= r_d;
            quot_q  <= quot_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out      = out_q;
    assign overflow = ovf_q;
    assign done     = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_fixed_p_std_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fixed_p_std_div_seq
//  Purpose  : Directed self-checking bench for the sequential fixed-point
//             divider (8/4/4 and default 32/8/24 instances).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fixed_p_std_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        go8, go32;
    logic [7:0]  l8, r8, o8;
    logic        ov8, dn8;
    logic [31:0] l32, r32, o32;
    logic        ov32, dn32;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fixed_p_std_div_seq #(.width(8), .int_width(4), .fract_width(4)) dut8 (
        .clk(clk), .reset(reset), .go(go8), .left(l8), .right(r8),
        .out(o8), .overflow(ov8), .done(dn8)
    );

    fixed_p_std_div_seq dut32 (
        .clk(clk), .reset(reset), .go(go32), .left(l32), .right(r32),
        .out(o32), .overflow(ov32), .done(dn32)
    );

    // Launch one operation and observe it; no checking here.
    // lat = cycles from the go-sampling edge to the first done (-1 on timeout).
    task automatic run_op(input bit big, input logic [31:0] l, input logic [31:0] r,
                          input bit disturb, output int lat, output logic [31:0] o,
                          output logic ovf, output logic [31:0] mid_o,
                          output logic extra_done);
        @(negedge clk);
        if (big) begin go32 = 1'b1; l32 = l; r32 = r; end
        else     begin go8 = 1'b1; l8 = l[7:0]; r8 = r[7:0]; end
        @(posedge clk);
        #1;
        go8 = 1'b0; go32 = 1'b0;
        lat = -1; mid_o = '0;
        for (int j = 1; j <= 80; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 5) mid_o = big ? o32 : {24'h0, o8};
            if (disturb && j == 10) begin go32 = 1'b1; l32 = 32'h7F000000; r32 = 32'h00100000; end
            if (disturb && j == 11) go32 = 1'b0;
            if ((big ? dn32 : dn8) === 1'b1) begin lat = j; break; end
        end
        o   = big ? o32 : {24'h0, o8};
        ovf = big ? ov32 : ov8;
        @(posedge clk);
        @(negedge clk);
        extra_done = big ? dn32 : dn8;
    endtask

    task automatic test_reset();
        reset = 1'b0; go8 = 1'b0; go32 = 1'b0;
        l8 = '0; r8 = '0; l32 = '0; r32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (o8 !== 8'h00) begin errors++; $display("FAIL reset_out8: got %h want 00", o8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_ovf8: got %b want 0", ov8); end
        checks++; if (dn8 !== 1'b0) begin errors++; $display("FAIL reset_done8: got %b want 0", dn8); end
        checks++; if (o32 !== 32'h0) begin errors++; $display("FAIL reset_out32: got %h want 0", o32); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_small_vectors();
        logic [7:0] tl [4] = '{8'h30, 8'h10, 8'hF0, 8'h55};
        logic [7:0] tr [4] = '{8'h20, 8'h30, 8'h01, 8'h00};
        logic [7:0] eo [4] = '{8'h18, 8'h05, 8'h00, 8'hFF};
        logic       ev [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] prev = 8'h00;
        int lat; logic [31:0] o, mid; logic ovf, xd;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b0, {24'h0, tl[i]}, {24'h0, tr[i]}, 1'b0, lat, o, ovf, mid, xd);
            checks++; if (o[7:0] !== eo[i]) begin errors++; $display("FAIL div8_out[%0d]: got %h want %h", i, o[7:0], eo[i]); end
            checks++; if (ovf !== ev[i]) begin errors++; $display("FAIL div8_ovf[%0d]: got %b want %b", i, ovf, ev[i]); end
            checks++; if (lat != 12) begin errors++; $display("FAIL div8_latency[%0d]: got %0d want 12", i, lat); end
            checks++; if (xd !== 1'b0) begin errors++; $display("FAIL div8_done_width[%0d]: got %b want 0", i, xd); end
            checks++; if (mid[7:0] !== prev) begin errors++; $display("FAIL div8_hold_during_run[%0d]: got %h want %h", i, mid[7:0], prev); end
            prev = eo[i];
        end
    endtask

    task automatic test_default_disturb();
        int lat; logic [31:0] o, mid; logic ovf, xd;
        run_op(1'b1, 32'h0A000000, 32'h04000000, 1'b1, lat, o, ovf, mid, xd);
        checks++; if (o !== 32'h02800000) begin errors++; $display("FAIL div32_out: got %h want 02800000", o); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL div32_ovf: got %b want 0", ovf); end
        checks++; if (lat != 56) begin errors++; $display("FAIL div32_latency: got %0d want 56", lat); end
        checks++; if (xd !== 1'b0) begin errors++; $display("FAIL div32_done_width: got %b want 0", xd); end
        checks++; if (mid !== 32'h0) begin errors++; $display("FAIL div32_hold_during_run: got %h want 0", mid); end
    endtask

    task automatic test_async_reset();
        int lat; int seen; logic [31:0] o, mid; logic ovf, xd;
        @(negedge clk);
        go32 = 1'b1; l32 = 32'h0A000000; r32 = 32'h04000000;
        @(posedge clk);
        #1 go32 = 1'b0;
        repeat (20) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (o32 !== 32'h0) begin errors++; $display("FAIL areset_out_cleared: got %h want 0", o32); end
        checks++; if (ov32 !== 1'b0) begin errors++; $display("FAIL areset_ovf_cleared: got %b want 0", ov32); end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        seen = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (dn32 === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL areset_no_done: got %0d done pulses want 0", seen); end
        checks++; if (o32 !== 32'h0) begin errors++; $display("FAIL areset_out_after: got %h want 0", o32); end
        run_op(1'b1, 32'h01000000, 32'h03000000, 1'b0, lat, o, ovf, mid, xd);
        checks++; if (o !== 32'h00555555) begin errors++; $display("FAIL areset_fresh_out: got %h want 00555555", o); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL areset_fresh_ovf: got %b want 0", ovf); end
        checks++; if (lat != 56) begin errors++; $display("FAIL areset_fresh_latency: got %0d want 56", lat); end
    endtask

    task automatic test_back_to_back();
        int j1 = -1, j2 = -1;
        logic [7:0] o1 = 8'h00, o2 = 8'h00;
        @(negedge clk);
        go8 = 1'b1; l8 = 8'h30; r8 = 8'h20;
        @(posedge clk);
        #1 l8 = 8'h10; r8 = 8'h30;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (dn8 === 1'b1) begin
                if (j1 < 0) begin j1 = j; o1 = o8; end
                else begin j2 = j; o2 = o8; go8 = 1'b0; break; end
            end
        end
        go8 = 1'b0;
        checks++; if (j1 != 12) begin errors++; $display("FAIL b2b_first_latency: got %0d want 12", j1); end
        checks++; if (o1 !== 8'h18) begin errors++; $display("FAIL b2b_first_out: got %h want 18", o1); end
        checks++; if (j2 != 26) begin errors++; $display("FAIL b2b_second_latency: got %0d want 26", j2); end
        checks++; if (o2 !== 8'h05) begin errors++; $display("FAIL b2b_second_out: got %h want 05", o2); end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_small_vectors();
        test_default_disturb();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_p_std_div_seq.md
Name: fixed_p_std_div_seq

Overview:
- Synthesizable, multi-cycle unsigned fixed-point divider with a go/done interface.
- Replaces the combinational, unsynthesizable fixed-point divide wherever a Calyx component needs a real division in hardware.
- Consumes the same operand format as the fixed-point add/sub/mult primitives and feeds the same downstream consumers.
- Computes floor((left << fract_width) / right) with a restoring algorithm, one quotient bit per cycle.

Parameters:
width, 32, total operand/result width in bits
int_width, 8, integer bits; must satisfy int_width + fract_width == width
fract_width, 24, fraction bits

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
go  input  1  start request, sampled only in IDLE
left  input  width  dividend, unsigned fixed-point, sampled with go
right  input  width  divisor, unsigned fixed-point, sampled with go
out  output  width  quotient, unsigned fixed-point, same format as operands
overflow  output  1  quotient did not fit in width bits (includes divide-by-zero)
done  output  1  one-cycle pulse: out and overflow are valid and updated

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE; out = 0, overflow = 0, done = 0.
  - Internal registers cleared.
  - An in-flight operation is abandoned with no done.
- N = width + fract_width iterations (default 56).
- States: IDLE, RUN, DONE.
- IDLE:
  - go == 1 at edge k: latch dividend D = {left, fract_width zeros} (N bits) and divisor V = right.
  - Clear remainder R (width+1 bits) and quotient Q (N bits); count = 0; go to RUN.
  - go == 0: stay in IDLE.
- RUN, one iteration per edge, edges k+1 .. k+N:
  - T = {R[width-1:0], D[N-1]}; D <<= 1.
  - If T >= V: R = T - V, shift 1 into Q LSB; else R = T, shift 0 into Q LSB.
  - count++.
  - At the edge completing iteration N: go to DONE.
  - On that same edge: out <= Q_final[width-1:0] and overflow <= |Q_final[N-1:width].
- DONE:
  - done = 1 for exactly one cycle (between edges k+N and k+N+1).
  - Next edge: return to IDLE unconditionally.
- Latency: done asserted N cycles after the edge that sampled go.
- go while busy:
  - Ignored in RUN and DONE; no queuing.
  - go held high through DONE starts a new operation only from IDLE, one cycle after done.
- Operand changes after the sampling edge have no effect.
- out/overflow hold their last value until the next done; they do not change during RUN.
- Divide by zero (right == 0):
  - No special path; the algorithm yields Q = all ones.
  - Result: out = all ones and overflow = 1 (fract_width > 0), with normal latency.
- Arithmetic:
  - Purely unsigned.
  - Truncating (floor), no rounding.
  - Result is the low width bits of the N-bit quotient.
- Parameter check: elaboration error if int_width + fract_width != width.

Decomposition:
- Package fixed_p_div_pkg:
  - state enum typedef (IDLE, RUN, DONE).
  - Function computing N and the counter width $clog2(N+1).
- One sub-module, fixed_p_div_step: combinational single restoring step.
  - Inputs: R, next dividend bit, V.
  - Outputs: new R, quotient bit.
- Top-level holds the FSM, shift registers, counter and output registers.

Test Plan:
- width=8, int_width=4, fract_width=4; go with left=0x30 (3.0), right=0x20 (2.0) -> out=0x18 (1.5), overflow=0, done high exactly 12 cycles after the go-sampling edge, one cycle wide.
- Same config; left=0x10 (1.0), right=0x30 (3.0) -> out=0x05 (0.3125, truncated), overflow=0.
- Same config; left=0xF0 (15.0), right=0x01 (0.0625) -> true quotient 240.0 -> out=0x00, overflow=1.
- Same config; right=0x00, left=0x55 -> out=0xFF, overflow=1, done at normal latency.
- Default 32/8/24; left=0x0A000000 (10.0), right=0x04000000 (4.0) -> out=0x02800000 (2.5) after 56 cycles; go pulsed again mid-RUN is ignored; left/right changed mid-RUN do not alter the result.
- Default config; reset driven low asynchronously at iteration 20, released 3 cycles later -> done never asserted for that operation, out=0, overflow=0. A fresh go then completes normally with the correct result.
